// File: rtl/stt_pkg.sv
// stt_pkg: shared types and helpers for the state-transition-table engine.
//   mode_e    - run-controller modes
//   entry_t   - one table entry at the default widths
//   entry_idx - flat table index {state,in}
package stt_pkg;
  localparam int STT_STATE_W = 2;
  localparam int STT_IN_W = 1;
  localparam int STT_OUT_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, ERR} mode_e;
  typedef struct packed {
    logic                   valid;
    logic [STT_STATE_W-1:0] next;
    logic [STT_OUT_W-1:0]   out;
  } entry_t;
  function automatic int unsigned entry_idx(int unsigned state, int unsigned in, int unsigned in_w);
    return (state << in_w) | in;
  endfunction
endpackage

// File: rtl/stt_table_ram.sv
// stt_table_ram: flop-based transition table, combinational read, synchronous write.
//   clk, rst_n      - clock, async active-low reset (valid bits only)
//   we, waddr       - write {wnext,wout} to waddr and mark it valid
//   clr             - invalidate every entry
//   raddr, rd_*     - combinational read of valid/next/out
module stt_table_ram #(
  parameter int AW = 3,
  parameter int STATE_W = 2,
  parameter int OUT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic               clr,
  input  logic [AW-1:0]      waddr,
  input  logic [STATE_W-1:0] wnext,
  input  logic [OUT_W-1:0]   wout,
  input  logic [AW-1:0]      raddr,
  output logic               rd_valid,
  output logic [STATE_W-1:0] rd_next,
  output logic [OUT_W-1:0]   rd_out
);
  localparam int DEPTH = 2**AW;
  logic [DEPTH-1:0]   valid;
  logic [STATE_W-1:0] next_q [DEPTH];
  logic [OUT_W-1:0]   out_q [DEPTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid <= '0;
    else if (clr) valid <= '0;
    else if (we) valid[waddr] <= 1'b1;
  end
  // Payload is deliberately left unreset; the valid bit guards every read.
  always_ff @(posedge clk) begin
    if (we) begin
      next_q[waddr] <= wnext;
      out_q[waddr] <= wout;
    end
  end
  assign rd_valid = valid[raddr];
  assign rd_next = next_q[raddr];
  assign rd_out = out_q[raddr];
endmodule

// File: rtl/stt_table_ctrl.sv
// stt_table_ctrl: programmable STT engine with IDLE/RUN/ERR run controller.
//   cfg_*        - table programming (IDLE only); cfg_ack/cfg_rej pulse next cycle
//   start/stop   - run control; start_state seeds cur_state
//   in_*         - input symbol stream (valid/ready)
//   out_*        - output word stream (valid/ready), registered
//   cur_state, busy, err, err_clr - status and error recovery
module stt_table_ctrl
  import stt_pkg::*;
#(
  parameter int STATE_W = STT_STATE_W,
  parameter int IN_W = STT_IN_W,
  parameter int OUT_W = STT_OUT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [STATE_W-1:0] cfg_state,
  input  logic [IN_W-1:0]    cfg_in,
  input  logic [STATE_W-1:0] cfg_next,
  input  logic [OUT_W-1:0]   cfg_out,
  input  logic               cfg_clr,
  output logic               cfg_ack,
  output logic               cfg_rej,
  input  logic               start,
  input  logic [STATE_W-1:0] start_state,
  input  logic               stop,
  input  logic               in_valid,
  input  logic [IN_W-1:0]    in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_data,
  input  logic               out_ready,
  output logic [STATE_W-1:0] cur_state,
  output logic               busy,
  output logic               err,
  input  logic               err_clr
);
  localparam int AW = STATE_W + IN_W;
  mode_e mode, mode_nx;
  logic idle, run, acc, hit, cfg_op;
  logic [AW-1:0] waddr, raddr;
  logic rd_valid;
  logic [STATE_W-1:0] rd_next;
  logic [OUT_W-1:0] rd_out;
  assign idle = mode == IDLE;
  assign run = mode == RUN;
  assign cfg_op = cfg_we || cfg_clr;
  assign in_ready = run && !stop && (!out_valid || out_ready);
  assign acc = in_valid && in_ready;
  assign hit = acc && rd_valid;
  assign busy = !idle;
  assign err = mode == ERR;
  assign waddr = AW'(entry_idx(32'(cfg_state), 32'(cfg_in), IN_W));
  assign raddr = AW'(entry_idx(32'(cur_state), 32'(in_data), IN_W));
  stt_table_ram #(.AW(AW), .STATE_W(STATE_W), .OUT_W(OUT_W)) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (idle && cfg_we && !cfg_clr),
    .clr      (idle && cfg_clr),
    .waddr    (waddr),
    .wnext    (cfg_next),
    .wout     (cfg_out),
    .raddr    (raddr),
    .rd_valid (rd_valid),
    .rd_next  (rd_next),
    .rd_out   (rd_out)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode <= IDLE;
    else mode <= mode_nx;
  end
  // stop beats start in IDLE and beats any accept in RUN.
  always_comb begin
    mode_nx = mode;
    mode_nx = idle ? ((start && !stop) ? RUN : IDLE)
            : run  ? (stop ? IDLE : (acc && !rd_valid) ? ERR : RUN)
            : (err_clr ? IDLE : ERR);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      cfg_ack <= 1'b0;
      cfg_rej <= 1'b0;
    end else begin
      cfg_ack <= idle && cfg_op;
      cfg_rej <= !idle && cfg_op;
      if (idle && start && !stop) cur_state <= start_state;
      else if (hit) cur_state <= rd_next;
      // A pending word survives stop and IDLE until the consumer takes it.
      out_valid <= hit || (out_valid && !out_ready);
      if (hit) out_data <= rd_out;
    end
  end
endmodule

// File: tb/tb_stt_table_ctrl.sv
// tb_stt_table_ctrl: directed + randomized checks of stt_table_ctrl against a table-walk model.
module tb_stt_table_ctrl;
  import stt_pkg::*;
  logic clk = 0, rst_n = 0;
  logic cfg_we = 0, cfg_clr = 0, cfg_ack, cfg_rej;
  logic [1:0] cfg_state = 0, cfg_next = 0, start_state = 0, cur_state;
  logic cfg_in = 0, in_data = 0;
  logic [7:0] cfg_out = 0, out_data;
  logic start = 0, stop = 0, in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic busy, err, err_clr = 0;
  int total = 0, bad = 0;
  entry_t mt [8];
  mode_e m_mode = IDLE;
  logic [1:0] m_cur = 0;
  logic m_ov = 0;
  logic [7:0] m_od = 0;
  int plan_out [5] = '{1, 3, 5, 6, 0};
  int plan_in [5] = '{1, 1, 1, 0, 0};
  always #5 clk = ~clk;
  stt_table_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_state(cfg_state), .cfg_in(cfg_in),
    .cfg_next(cfg_next), .cfg_out(cfg_out), .cfg_clr(cfg_clr), .cfg_ack(cfg_ack),
    .cfg_rej(cfg_rej), .start(start), .start_state(start_state), .stop(stop),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .cur_state(cur_state), .busy(busy),
    .err(err), .err_clr(err_clr)
  );
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_outs(string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, ".out_data"}, 32'(out_data), 32'(m_od));
    chk({tag, ".cur_state"}, 32'(cur_state), 32'(m_cur));
    chk({tag, ".busy"}, 32'(busy), 32'(m_mode != IDLE));
    chk({tag, ".err"}, 32'(err), 32'(m_mode == ERR));
  endtask
  task automatic quiet_tick();
    in_valid = 0;
    out_ready = 1;
    tick();
    m_ov = 0;
  endtask
  task automatic cyc(bit iv, logic d, bit ordy);
    logic exp_rdy;
    int i;
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    #1;
    exp_rdy = (m_mode == RUN) && (!m_ov || ordy);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    i = int'(m_cur) * 2 + int'(d);
    if (iv && exp_rdy && !mt[i].valid) m_mode = ERR;
    if (iv && exp_rdy && mt[i].valid) begin
      m_ov = 1;
      m_od = mt[i].out;
      m_cur = mt[i].next;
    end else if (ordy) m_ov = 0;
    tick();
    in_valid = 0;
    chk_outs("step");
  endtask
  task automatic cfg_wr(logic [1:0] s, logic i, logic [1:0] n, logic [7:0] o);
    bit ok;
    ok = m_mode == IDLE;
    cfg_we = 1;
    cfg_state = s;
    cfg_in = i;
    cfg_next = n;
    cfg_out = o;
    quiet_tick();
    cfg_we = 0;
    chk("cfg_wr.ack", 32'(cfg_ack), 32'(ok));
    chk("cfg_wr.rej", 32'(cfg_rej), 32'(!ok));
    if (ok) mt[int'(s) * 2 + int'(i)] = {1'b1, n, o};
  endtask
  task automatic cfg_clear();
    bit ok;
    ok = m_mode == IDLE;
    cfg_clr = 1;
    cfg_we = 1;
    cfg_state = 0;
    cfg_in = 0;
    quiet_tick();
    cfg_clr = 0;
    cfg_we = 0;
    chk("cfg_clr.ack", 32'(cfg_ack), 32'(ok));
    chk("cfg_clr.rej", 32'(cfg_rej), 32'(!ok));
    if (ok) for (int k = 0; k < 8; k++) mt[k].valid = 0;
  endtask
  task automatic load_plan();
    cfg_wr(0, 0, 2, 0); cfg_wr(0, 1, 1, 1);
    cfg_wr(1, 0, 1, 2); cfg_wr(1, 1, 2, 3);
    cfg_wr(2, 0, 2, 4); cfg_wr(2, 1, 3, 5);
    cfg_wr(3, 0, 0, 6); cfg_wr(3, 1, 3, 7);
  endtask
  task automatic start_run(logic [1:0] s);
    start = 1;
    start_state = s;
    quiet_tick();
    start = 0;
    if (m_mode == IDLE) begin
      m_mode = RUN;
      m_cur = s;
    end
    chk_outs("start");
  endtask
  task automatic stop_run(bit iv);
    stop = 1;
    in_valid = iv;
    out_ready = 1;
    #1;
    chk("stop.in_ready", 32'(in_ready), 0);
    tick();
    stop = 0;
    in_valid = 0;
    if (m_mode == RUN) m_mode = IDLE;
    m_ov = 0;
    chk_outs("stop");
  endtask
  task automatic err_clear();
    err_clr = 1;
    quiet_tick();
    err_clr = 0;
    if (m_mode == ERR) m_mode = IDLE;
    chk_outs("err_clr");
  endtask
  initial begin
    for (int k = 0; k < 8; k++) mt[k] = '0;
    #1;
    chk_outs("reset");
    chk("reset.cfg_ack", 32'(cfg_ack), 0);
    chk("reset.cfg_rej", 32'(cfg_rej), 0);
    chk("reset.in_ready", 32'(in_ready), 0);
    #11 rst_n = 1;
    tick();
    // Plan stream at full rate
    load_plan();
    start_run(0);
    for (int k = 0; k < 5; k++) begin
      cyc(1, plan_in[k][0], 1);
      chk("plan.out", 32'(out_data), 32'(plan_out[k]));
    end
    chk("plan.final_state", 32'(cur_state), 2);
    cyc(0, 0, 1);
    stop_run(0);
    // Backpressure after first output
    start_run(0);
    cyc(1, 1, 1);
    for (int k = 0; k < 3; k++) cyc(1, 1, 0);
    chk("bp.held", 32'(out_data), 1);
    for (int k = 1; k < 5; k++) cyc(1, plan_in[k][0], 1);
    chk("bp.final_state", 32'(cur_state), 2);
    cyc(0, 0, 1);
    stop_run(0);
    // Random table, random traffic
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 2; i++) cfg_wr(2'(s), 1'(i), 2'($urandom_range(0, 3)), 8'($urandom));
    start_run(2'($urandom_range(0, 3)));
    for (int k = 0; k < 150; k++) cyc(1'($urandom_range(0, 1)), 1'($urandom), $urandom_range(0, 3) != 0);
    stop_run(0);
    // Unprogrammed entry
    cfg_clear();
    cfg_wr(0, 0, 2, 0);
    cfg_wr(0, 1, 1, 1);
    start_run(0);
    cyc(1, 1, 1);
    chk("unprog.first", 32'(out_data), 1);
    cyc(1, 0, 1);
    chk("unprog.err", 32'(err), 1);
    chk("unprog.state", 32'(cur_state), 1);
    cyc(1, 0, 1);
    err_clear();
    chk("unprog.busy", 32'(busy), 0);
    // Config rejection outside IDLE
    start_run(1);
    cfg_wr(1, 0, 3, 8'haa);
    quiet_tick();
    chk("rej.pulse_end", 32'(cfg_rej), 0);
    stop_run(0);
    start_run(1);
    cyc(1, 0, 1);
    cfg_wr(1, 0, 3, 8'h55);
    err_clear();
    cfg_clear();
    start_run(0);
    cyc(1, 1, 1);
    err_clear();
    // start+stop together, stop with a symbol offered
    load_plan();
    start = 1;
    stop = 1;
    quiet_tick();
    start = 0;
    stop = 0;
    chk_outs("start_stop");
    start_run(0);
    in_data = 1;
    stop_run(1);
    // Async reset mid-run with a pending word
    start_run(0);
    cyc(1, 1, 0);
    #2 rst_n = 0;
    #1;
    for (int k = 0; k < 8; k++) mt[k].valid = 0;
    m_mode = IDLE;
    m_cur = 0;
    m_ov = 0;
    m_od = 0;
    chk_outs("arst");
    chk("arst.in_ready", 32'(in_ready), 0);
    chk("arst.cfg_ack", 32'(cfg_ack), 0);
    #3 rst_n = 1;
    tick();
    start_run(0);
    cyc(1, 1'($urandom), 1);
    chk("arst.err", 32'(err), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
